arith_seq_unit: RTL and testbench
=================================

Name: arith_seq_unit

Overview:
- Parametrised, handshaked successor to the 16-bit combinational arithmetic unit.
- Accepts one operand pair plus opcode per transaction and returns a double-width result.
- Adds an iterative multi-cycle divider and valid/ready flow control on both sides.
- Sits between command decode and the address/timing calculators in the controller datapath.

Parameters:
- WIDTH, 16: operand width in bits; result width is 2*WIDTH; legal range 4..32.
- SHW, $clog2(WIDTH): shift-amount width. Derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  unit can accept a transaction.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- opcode  input  3  operation select.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- outau  output  2*WIDTH  result.
- div_zero  output  1  last result came from a divide by zero; valid while out_valid is high.

Behaviour:
- Opcodes:
  - 000 ADD: {0.., a+b}; carry lands in bit WIDTH.
  - 001 SUB: a-b as a 2*WIDTH two's-complement value (operands zero-extended first).
  - 010 MUL: full a*b.
  - 011 DIV: {remainder, quotient}, each WIDTH bits.
  - 100 AND, 101 OR, 110 XOR: zero-extended.
  - 111 SHL: zero-extended a shifted left by b[SHW-1:0].
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, opcode. Go to DIV if opcode=011, else to DONE with outau computed in that same edge.
  - DIV: restoring divider, one quotient bit per cycle, WIDTH cycles, then DONE.
  - DONE: out_valid=1. outau and div_zero stay stable until out_valid&&out_ready, then return to IDLE.
- Latency from the accept edge to out_valid high:
  - Non-divide ops: 1 cycle.
  - Divide: WIDTH+1 cycles.
- Throughput: the next transaction can be accepted at most one cycle after the output handshake. in_ready is never high in the same cycle as out_valid.
- in_valid while in_ready=0 is ignored; the input side holds its data.
- Divide by zero: quotient all ones, remainder=a, div_zero=1. The divide still takes the full WIDTH+1 cycles.
- out_ready held high continuously: a result is consumed in its first valid cycle.
- Reset:
  - state=IDLE, in_ready=1, out_valid=0, outau=0, div_zero=0.
  - Reset in any state, including mid-divide, aborts the operation; no partial result is emitted.
- No overflow traps. ADD/MUL cannot overflow 2*WIDTH bits. SUB underflow gives upper bits all ones.

Optional Feature:
- Macro: ARITH_FLAGS_EN.
- Defined: adds output port flags[2:0], registered with outau and valid only while out_valid is high.
  - [0] zero: outau==0.
  - [1] carry/borrow: ADD carry out, or SUB a<b.
  - [2] msb: outau[2*WIDTH-1].
  - Reset value 0.
- Undefined: port absent, no flag logic.

Decomposition:
- Package arith_pkg:
  - opcode constants OP_ADD..OP_SHL.
  - FSM state encoding (IDLE, DIV, DONE).
- Sub-module arith_div_seq: start/busy/done restoring divider, WIDTH-parametrised, with a divide-by-zero output. The top module handles the FSM, single-cycle ops and output registers.

Test Plan (WIDTH=16):
- Reset then ADD a=0x0001 b=0x0010, out_ready=1 -> out_valid exactly 1 cycle after accept, outau=0x00000011, in_ready high the cycle after the handshake.
- SUB a=0x0100 b=0x0110; MUL a=0xFFFF b=0xFFFF -> outau=0xFFFFFFF0 and 0xFFFE0001 respectively.
- DIV a=0x0110 b=0x0010 -> out_valid 17 cycles after accept, outau=0x00000011, div_zero=0. DIV a=0x0005 b=0 -> outau=0x0005FFFF, div_zero=1.
- Backpressure: XOR a=0x00FF b=0x0F0F with out_ready=0 for 5 cycles -> outau=0x00000FF0 held stable, in_ready=0, new in_valid ignored until the handshake.
- Assert rst_n=0 for 1 cycle, 4 cycles into a DIV -> next edge: out_valid=0, outau=0, in_ready=1, no stale result appears afterwards.
- With ARITH_FLAGS_EN: SUB a=0x0001 b=0x0002 -> outau=0xFFFFFFFF, flags=3'b110. AND a=0x00F0 b=0x000F -> flags=3'b001.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared opcode constants and FSM state encoding for the sequenced arithmetic unit.
package arith_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/arith_div_seq.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so the full quotient is ready WIDTH edges later.
module arith_div_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_src;
  logic [WIDTH-1:0] quo_src;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // One restoring step; operands come straight from the ports on the start edge.
  always_comb begin
    rem_src = start ? '0 : remainder;
    quo_src = start ? dividend : quotient;
    dvs     = start ? divisor : divisor_q;
    shifted = {rem_src, quo_src[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs};
    rem_nx  = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    quo_nx  = {quo_src[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      divisor_q <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy      <= 1'b1;
        count     <= CW'(WIDTH - 1);
        divisor_q <= divisor;
        quotient  <= quo_nx;
        remainder <= rem_nx;
        div_zero  <= (divisor == '0);
      end else if (busy) begin
        quotient  <= quo_nx;
        remainder <= rem_nx;
        count     <= count - CW'(1);
        if (count == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arith_seq_unit.sv
// Handshaked arithmetic unit: single-cycle ALU ops plus an iterative divider.
// Define ARITH_FLAGS_EN to add the registered zero/carry/msb flags output.
module arith_seq_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] outau,
`ifdef ARITH_FLAGS_EN
  output logic [2:0]         flags,
`endif
  output logic               div_zero
);

  localparam int unsigned RW  = 2 * WIDTH;
  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           state;
  logic             accept_c;
  logic             div_start_c;
  logic [WIDTH:0]   sum_c;
  logic [RW-1:0]    result_c;
  logic [RW-1:0]    next_res_c;
  logic             div_busy;
  logic             div_done;
  logic             div_dz;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign accept_c    = in_valid && in_ready;
  assign div_start_c = accept_c && (opcode == OP_DIV);

  arith_div_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start_c),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .div_zero  (div_dz)
  );

  // Single-cycle operations, evaluated on the accept edge.
  always_comb begin
    sum_c    = {1'b0, a} + {1'b0, b};
    result_c = '0;
    case (opcode)
      OP_ADD:  result_c = RW'(sum_c);
      OP_SUB:  result_c = RW'(a) - RW'(b);
      OP_MUL:  result_c = RW'(a) * RW'(b);
      OP_AND:  result_c = RW'(a & b);
      OP_OR:   result_c = RW'(a | b);
      OP_XOR:  result_c = RW'(a ^ b);
      OP_SHL:  result_c = RW'(a) << b[SHW-1:0];
      default: result_c = '0;
    endcase
    next_res_c = (state == ST_DIV) ? {div_rem, div_quo} : result_c;
  end

`ifdef ARITH_FLAGS_EN
  logic       carry_c;
  logic [2:0] next_flags_c;

  always_comb begin
    carry_c = 1'b0;
    if (state != ST_DIV) begin
      if (opcode == OP_ADD)      carry_c = sum_c[WIDTH];
      else if (opcode == OP_SUB) carry_c = (a < b);
    end
    next_flags_c = {next_res_c[RW-1], carry_c, (next_res_c == '0)};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      outau     <= '0;
      div_zero  <= 1'b0;
`ifdef ARITH_FLAGS_EN
      flags     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            in_ready <= 1'b0;
            if (opcode == OP_DIV) begin
              state <= ST_DIV;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              outau     <= next_res_c;
              div_zero  <= 1'b0;
`ifdef ARITH_FLAGS_EN
              flags     <= next_flags_c;
`endif
            end
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            outau     <= next_res_c;
            div_zero  <= div_dz;
`ifdef ARITH_FLAGS_EN
            flags     <= next_flags_c;
`endif
          end else if (!div_busy) begin
            // Divider lost its operation; recover rather than hang.
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Self-checking bench for arith_seq_unit (WIDTH=16): directed vectors plus a
// per-cycle comparison against an arithmetic reference model.
module tb_arith_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] outau;
  logic        div_zero;
`ifdef ARITH_FLAGS_EN
  logic [2:0]  flags;
  logic [2:0]  last_flags;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t exp_q[$];

  arith_seq_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outau     (outau),
`ifdef ARITH_FLAGS_EN
    .flags     (flags),
`endif
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result straight from the operation definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] x,
                                 input logic [15:0] y, input int acc);
    exp_t m;
    int unsigned ux = x;
    int unsigned uy = y;
    logic [31:0] r;
    case (op)
      3'd0: r = ux + uy;
      3'd1: r = ux - uy;
      3'd2: r = ux * uy;
      3'd3: r = (uy == 0) ? {x, 16'hFFFF} : (((ux % uy) << 16) | (ux / uy));
      3'd4: r = ux & uy;
      3'd5: r = ux | uy;
      3'd6: r = ux ^ uy;
      default: r = ux << (uy % 16);
    endcase
    m.res  = r;
    m.dz   = (op == 3'd3) && (uy == 0);
    m.lat  = (op == 3'd3) ? 17 : 1;
    m.acc  = acc;
    m.seen = 1'b0;
    return m;
  endfunction

  // Per-cycle compare against the model queue.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1) begin
        check("in_ready_while_out_valid", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          check("stale_result", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!exp_q[0].seen) begin
            exp_q[0].seen = 1'b1;
            check("model_latency", cyc - exp_q[0].acc, exp_q[0].lat);
          end
          check("model_outau", outau, exp_q[0].res);
          check("model_div_zero", {31'd0, div_zero}, {31'd0, exp_q[0].dz});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1)
        exp_q.push_back(model(opcode, a, b, cyc));
    end
  end

  task automatic run_op(input string nm, input logic [2:0] op, input logic [15:0] x,
                        input logic [15:0] y, input logic [31:0] exp_res,
                        input logic exp_dz, input int exp_lat);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_latency"}, n, exp_lat);
    check({nm, "_outau"}, outau, exp_res);
    check({nm, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
`ifdef ARITH_FLAGS_EN
    last_flags = flags;
`endif
    @(posedge clk); #1;
    check({nm, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int hits;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_outau", outau, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;

    run_op("add",      3'b000, 16'h0001, 16'h0010, 32'h0000_0011, 1'b0, 1);
    run_op("add_carry",3'b000, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE, 1'b0, 1);
    run_op("sub",      3'b001, 16'h0100, 16'h0110, 32'hFFFF_FFF0, 1'b0, 1);
    run_op("mul",      3'b010, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1);
    run_op("div",      3'b011, 16'h0110, 16'h0010, 32'h0000_0011, 1'b0, 17);
    run_op("div_zero", 3'b011, 16'h0005, 16'h0000, 32'h0005_FFFF, 1'b1, 17);
    run_op("div_rem",  3'b011, 16'hFFFF, 16'h0007, 32'h0001_2492, 1'b0, 17);
    run_op("or",       3'b101, 16'hF000, 16'h000F, 32'h0000_F00F, 1'b0, 1);
    run_op("shl",      3'b111, 16'h0003, 16'h0004, 32'h0000_0030, 1'b0, 1);
    run_op("shl_mask", 3'b111, 16'hFFFF, 16'h0013, 32'h0007_FFF8, 1'b0, 1);

    // Backpressure: result held, new request ignored until the handshake.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 3'b110; a = 16'h00FF; b = 16'h0F0F;
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 3'b100; a = 16'h1234; b = 16'h5678;
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_outau_held", outau, 32'h0000_0FF0);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
    check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("bp_request_ignored", exp_q.size(), 32'd0);

    // Reset four cycles into a divide.
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 3'b011; a = 16'h1234; b = 16'h0007;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_outau", outau, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    hits = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) hits++;
    end
    check("rst_mid_no_stale", hits, 32'd0);

    run_op("post_reset_xor", 3'b110, 16'hAAAA, 16'h5555, 32'h0000_FFFF, 1'b0, 1);

`ifdef ARITH_FLAGS_EN
    run_op("flag_sub", 3'b001, 16'h0001, 16'h0002, 32'hFFFF_FFFF, 1'b0, 1);
    check("flags_sub", {29'd0, last_flags}, 32'd6);
    run_op("flag_and", 3'b100, 16'h00F0, 16'h000F, 32'h0000_0000, 1'b0, 1);
    check("flags_and", {29'd0, last_flags}, 32'd1);
    run_op("flag_add", 3'b000, 16'h8000, 16'h8000, 32'h0001_0000, 1'b0, 1);
    check("flags_add_carry", {29'd0, last_flags}, 32'd2);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("model_queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
